// File: rtl/ic_stim_gen_if.sv
// Stimulus-generator bus: run control, checker handshake and per-pin pad drive.
// The generator uses the slave modport; the sequencing/checker side uses master.
interface ic_stim_gen_if #(
    parameter int NUM_PINS = 14,
    parameter int MAX_IN   = 3
);
    logic                start;
    logic                abort;
    logic [3:0]          ic_type;
    logic                ack;
    logic [NUM_PINS-1:0] pin_out;
    logic [NUM_PINS-1:0] pin_oe;
    logic [MAX_IN-1:0]   vec_idx;
    logic                sample_valid;
    logic                busy;
    logic                done;
    logic                unsupported;

    modport master (
        output start, abort, ic_type, ack,
        input  pin_out, pin_oe, vec_idx, sample_valid, busy, done, unsupported
    );

    modport slave (
        input  start, abort, ic_type, ack,
        output pin_out, pin_oe, vec_idx, sample_valid, busy, done, unsupported
    );
endinterface

// File: rtl/ic_stim_gen.sv
// Exhaustive truth-table stimulus for 14-pin logic ICs: drives gate inputs,
// releases outputs/supplies, holds each vector SETTLE_CYC cycles, then hands off.
//
// state  | meaning
// IDLE   | all pins released, waiting for start
// DRIVE  | vector applied, settle down-counter running
// SAMPLE | vector settled, sample_valid high until ack
module ic_stim_gen #(
    parameter int NUM_PINS   = 14,
    parameter int SETTLE_CYC = 4,
    parameter int MAX_IN     = 3
) (
    input  logic           clk,
    input  logic           rst_n,
    ic_stim_gen_if.slave   bus
);
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_DRIVE  = 2'd1;
    localparam logic [1:0] S_SAMPLE = 2'd2;

    localparam int              CNT_W    = $clog2(SETTLE_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYC - 1);

    logic [1:0]          state_q, state_d;
    logic [3:0]          type_q, type_d;
    logic [MAX_IN-1:0]   idx_q, idx_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                done_q, done_d;
    logic                unsup_q, unsup_d;
    logic [NUM_PINS-1:0] oe_q, oe_d;
    logic [NUM_PINS-1:0] out_q, out_d;

    function automatic logic [NUM_PINS-1:0] lay_mask(input logic [3:0] t);
        logic [NUM_PINS-1:0] m;
        m = '0;
        case (t)
            4'd0, 4'd1, 4'd2, 4'd3, 4'd4: begin
                m[0] = 1'b1; m[1]  = 1'b1; m[3]  = 1'b1; m[4]  = 1'b1;
                m[8] = 1'b1; m[9]  = 1'b1; m[11] = 1'b1; m[12] = 1'b1;
            end
            4'd5: begin
                m[1] = 1'b1; m[2]  = 1'b1; m[4]  = 1'b1; m[5]  = 1'b1;
                m[7] = 1'b1; m[8]  = 1'b1; m[10] = 1'b1; m[11] = 1'b1;
            end
            4'd6: begin
                m[0] = 1'b1; m[2]  = 1'b1; m[4]  = 1'b1;
                m[8] = 1'b1; m[10] = 1'b1; m[12] = 1'b1;
            end
            4'd7: begin
                m[0] = 1'b1; m[1]  = 1'b1; m[12] = 1'b1;
                m[2] = 1'b1; m[3]  = 1'b1; m[4]  = 1'b1;
                m[8] = 1'b1; m[9]  = 1'b1; m[10] = 1'b1;
            end
            default: m = '0;
        endcase
        return m;
    endfunction

    // Gate input k of every gate carries vector bit k.
    function automatic logic [NUM_PINS-1:0] lay_drive(input logic [3:0] t,
                                                      input logic [MAX_IN-1:0] v);
        logic [NUM_PINS-1:0] d;
        d = '0;
        case (t)
            4'd0, 4'd1, 4'd2, 4'd3, 4'd4: begin
                d[0] = v[0]; d[1]  = v[1]; d[3]  = v[0]; d[4]  = v[1];
                d[8] = v[0]; d[9]  = v[1]; d[11] = v[0]; d[12] = v[1];
            end
            4'd5: begin
                d[1] = v[0]; d[2]  = v[1]; d[4]  = v[0]; d[5]  = v[1];
                d[7] = v[0]; d[8]  = v[1]; d[10] = v[0]; d[11] = v[1];
            end
            4'd6: begin
                d[0] = v[0]; d[2]  = v[0]; d[4]  = v[0];
                d[8] = v[0]; d[10] = v[0]; d[12] = v[0];
            end
            4'd7: begin
                d[0] = v[0]; d[1]  = v[1]; d[12] = v[2];
                d[2] = v[0]; d[3]  = v[1]; d[4]  = v[2];
                d[8] = v[0]; d[9]  = v[1]; d[10] = v[2];
            end
            default: d = '0;
        endcase
        return d;
    endfunction

    function automatic logic [MAX_IN-1:0] last_idx(input logic [3:0] t);
        case (t)
            4'd6:    return MAX_IN'(1);
            4'd7:    return MAX_IN'(7);
            default: return MAX_IN'(3);
        endcase
    endfunction

    always_comb begin
        state_d = state_q;
        type_d  = type_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        unsup_d = 1'b0;
        if (bus.abort) begin
            state_d = S_IDLE;
            idx_d   = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        if (bus.ic_type[3]) begin
                            unsup_d = 1'b1;
                        end else begin
                            type_d  = bus.ic_type;
                            idx_d   = '0;
                            cnt_d   = CNT_LOAD;
                            state_d = S_DRIVE;
                        end
                    end
                end
                S_DRIVE: begin
                    if (cnt_q == '0) state_d = S_SAMPLE;
                    else             cnt_d   = cnt_q - CNT_W'(1);
                end
                S_SAMPLE: begin
                    if (bus.ack) begin
                        if (idx_q == last_idx(type_q)) begin
                            state_d = S_IDLE;
                            idx_d   = '0;
                            done_d  = 1'b1;
                        end else begin
                            idx_d   = idx_q + MAX_IN'(1);
                            cnt_d   = CNT_LOAD;
                            state_d = S_DRIVE;
                        end
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    idx_d   = '0;
                end
            endcase
        end
        // Pad controls are registered from next-state so they change in the entry cycle.
        oe_d  = '0;
        out_d = '0;
        if (state_d != S_IDLE) begin
            oe_d  = lay_mask(type_d);
            out_d = lay_drive(type_d, idx_d) & lay_mask(type_d);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            type_q  <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            unsup_q <= 1'b0;
            oe_q    <= '0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            type_q  <= type_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            unsup_q <= unsup_d;
            oe_q    <= oe_d;
            out_q   <= out_d;
        end
    end

    assign bus.pin_out      = out_q;
    assign bus.pin_oe       = oe_q;
    assign bus.vec_idx      = idx_q;
    assign bus.sample_valid = (state_q == S_SAMPLE);
    assign bus.busy         = (state_q != S_IDLE);
    assign bus.done         = done_q;
    assign bus.unsupported  = unsup_q;
endmodule

// File: tb/tb_ic_stim_gen.sv
// Scenario bench for ic_stim_gen: expected vectors are queued at start and
// popped as the generator presents each settled sample.
module tb_ic_stim_gen;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        int         t;
        logic [2:0] idx;
        logic [13:0] out;
    } exp_t;
    exp_t sb[$];

    ic_stim_gen_if #(.NUM_PINS(14), .MAX_IN(3)) bus();
    ic_stim_gen #(.NUM_PINS(14), .SETTLE_CYC(4), .MAX_IN(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic int pin_bit(int t, int p);
        int m[14];
        if (t <= 4)      m = '{0, 1, -1, 0, 1, -1, -1, -1, 0, 1, -1, 0, 1, -1};
        else if (t == 5) m = '{-1, 0, 1, -1, 0, 1, -1, 0, 1, -1, 0, 1, -1, -1};
        else if (t == 6) m = '{0, -1, 0, -1, 0, -1, -1, -1, 0, -1, 0, -1, 0, -1};
        else             m = '{0, 1, 0, 1, 2, -1, -1, -1, 0, 1, 2, -1, 2, -1};
        return m[p];
    endfunction

    function automatic logic [13:0] exp_oe(int t);
        if (t <= 4)      return 14'b01101100011011;
        else if (t == 5) return 14'b00110110110110;
        else if (t == 6) return 14'b01010100010101;
        else             return 14'b01011100011111;
    endfunction

    function automatic logic [13:0] exp_out(int t, int v);
        logic [13:0] r;
        int b;
        r = '0;
        for (int p = 0; p < 14; p++) begin
            b = pin_bit(t, p);
            if (b >= 0) r[p] = ((v >> b) & 1) == 1;
        end
        return r;
    endfunction

    function automatic int nvec(int t);
        if (t == 6) return 2;
        if (t == 7) return 8;
        return 4;
    endfunction

    task automatic push_run(int t);
        exp_t e;
        for (int v = 0; v < nvec(t); v++) begin
            e.t = t; e.idx = 3'(v); e.out = exp_out(t, v);
            sb.push_back(e);
        end
    endtask

    task automatic test_reset();
        #1;
        vectors++;
        if ({bus.busy, bus.sample_valid, bus.done, bus.unsupported} !== 4'b0) begin
            miscompares++;
            $display("FAIL reset_flags got %b exp 0000", {bus.busy, bus.sample_valid, bus.done, bus.unsupported});
        end
        vectors++;
        if (bus.pin_oe !== 14'b0 || bus.pin_out !== 14'b0 || bus.vec_idx !== 3'b0) begin
            miscompares++;
            $display("FAIL reset_pins got oe=%b out=%b idx=%0d exp all 0", bus.pin_oe, bus.pin_out, bus.vec_idx);
        end
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_type0_ack_high();
        exp_t e;
        int k;
        bus.ic_type = 4'd0; bus.ack = 1'b1; bus.start = 1'b1;
        push_run(0);
        for (int c = 1; c <= 24; c++) begin
            @(negedge clk);
            bus.start = 1'b0;
            vectors++;
            if (bus.pin_oe !== ((c <= 20) ? 14'b01101100011011 : 14'b0)) begin
                miscompares++;
                $display("FAIL t0_oe c=%0d got %b exp %b", c, bus.pin_oe, (c <= 20) ? 14'b01101100011011 : 14'b0);
            end
            vectors++;
            if (bus.sample_valid !== (c % 5 == 0 && c <= 20)) begin
                miscompares++;
                $display("FAIL t0_valid c=%0d got %b exp %b", c, bus.sample_valid, (c % 5 == 0 && c <= 20));
            end
            vectors++;
            if (bus.done !== (c == 21)) begin
                miscompares++;
                $display("FAIL t0_done c=%0d got %b exp %b", c, bus.done, (c == 21));
            end
            if (bus.sample_valid) begin
                k = c / 5 - 1;
                vectors++;
                if (bus.pin_out[1:0] !== 2'(((k >> 1) & 1) * 2 + (k & 1))) begin
                    miscompares++;
                    $display("FAIL t0_pin01 c=%0d got p0=%b p1=%b exp p0=%0d p1=%0d", c, bus.pin_out[0], bus.pin_out[1], k & 1, (k >> 1) & 1);
                end
                if (sb.size() == 0) begin
                    vectors++; miscompares++;
                    $display("FAIL t0_sb got empty exp entry");
                end else begin
                    e = sb.pop_front();
                    vectors++;
                    if (bus.vec_idx !== e.idx || bus.pin_out !== e.out) begin
                        miscompares++;
                        $display("FAIL t0_vec got idx=%0d out=%b exp idx=%0d out=%b", bus.vec_idx, bus.pin_out, e.idx, e.out);
                    end
                end
            end
        end
        vectors++;
        if (sb.size() !== 0) begin
            miscompares++;
            $display("FAIL t0_count got %0d left exp 0", sb.size());
        end
        sb.delete();
    endtask

    task automatic test_type5_type6();
        exp_t e;
        int nsamp;
        bit got_done;
        for (int t = 5; t <= 6; t++) begin
            nsamp = 0; got_done = 0;
            bus.ic_type = 4'(t); bus.ack = 1'b1; bus.start = 1'b1;
            push_run(t);
            for (int c = 1; c <= 100 && !got_done; c++) begin
                @(negedge clk);
                bus.start = 1'b0;
                vectors++;
                if (bus.pin_oe !== (bus.busy ? exp_oe(t) : 14'b0)) begin
                    miscompares++;
                    $display("FAIL t%0d_oe c=%0d got %b exp %b", t, c, bus.pin_oe, exp_oe(t));
                end
                vectors++;
                if ({bus.pin_oe[13], bus.pin_oe[6], bus.pin_out[13], bus.pin_out[6]} !== 4'b0) begin
                    miscompares++;
                    $display("FAIL t%0d_supply c=%0d got %b exp 0000", t, c, {bus.pin_oe[13], bus.pin_oe[6], bus.pin_out[13], bus.pin_out[6]});
                end
                if (bus.sample_valid) begin
                    nsamp++;
                    if (sb.size() == 0) begin
                        vectors++; miscompares++;
                        $display("FAIL t%0d_sb got empty exp entry", t);
                    end else begin
                        e = sb.pop_front();
                        vectors++;
                        if (bus.vec_idx !== e.idx || bus.pin_out !== e.out) begin
                            miscompares++;
                            $display("FAIL t%0d_vec got idx=%0d out=%b exp idx=%0d out=%b", t, bus.vec_idx, bus.pin_out, e.idx, e.out);
                        end
                    end
                end
                if (bus.done) got_done = 1;
            end
            vectors++;
            if (!got_done || nsamp != nvec(t)) begin
                miscompares++;
                $display("FAIL t%0d_run got done=%0b samples=%0d exp done=1 samples=%0d", t, got_done, nsamp, nvec(t));
            end
            sb.delete();
            @(negedge clk);
        end
    endtask

    task automatic test_type7_random_ack();
        exp_t e;
        int nsamp = 0;
        int wait_c = 0;
        bit seen = 0;
        bit got_done = 0;
        bus.ic_type = 4'd7; bus.ack = 1'b0; bus.start = 1'b1;
        push_run(7);
        for (int c = 1; c <= 300 && !got_done; c++) begin
            @(negedge clk);
            bus.start = 1'b0;
            bus.ack = 1'b0;
            vectors++;
            if ({bus.pin_oe[11], bus.pin_oe[7], bus.pin_oe[5]} !== 3'b0) begin
                miscompares++;
                $display("FAIL t7_outpins c=%0d got %b exp 000", c, {bus.pin_oe[11], bus.pin_oe[7], bus.pin_oe[5]});
            end
            if (bus.busy) begin
                vectors++;
                if (bus.pin_oe !== exp_oe(7)) begin
                    miscompares++;
                    $display("FAIL t7_oe c=%0d got %b exp %b", c, bus.pin_oe, exp_oe(7));
                end
            end
            if (!bus.sample_valid) seen = 0;
            else if (!seen) begin
                seen = 1; nsamp++;
                wait_c = $urandom_range(0, 3);
                if (sb.size() == 0) begin
                    vectors++; miscompares++;
                    $display("FAIL t7_sb got empty exp entry");
                end else begin
                    e = sb.pop_front();
                    vectors++;
                    if (bus.vec_idx !== e.idx || bus.pin_out !== e.out) begin
                        miscompares++;
                        $display("FAIL t7_vec got idx=%0d out=%b exp idx=%0d out=%b", bus.vec_idx, bus.pin_out, e.idx, e.out);
                    end
                    vectors++;
                    if ({bus.pin_out[12], bus.pin_out[1], bus.pin_out[0]} !== e.idx) begin
                        miscompares++;
                        $display("FAIL t7_gate0 got %b exp %b", {bus.pin_out[12], bus.pin_out[1], bus.pin_out[0]}, e.idx);
                    end
                end
            end
            if (seen) begin
                if (wait_c == 0) bus.ack = 1'b1;
                else wait_c--;
            end
            if (bus.done) got_done = 1;
        end
        bus.ack = 1'b0;
        vectors++;
        if (!got_done || nsamp != 8) begin
            miscompares++;
            $display("FAIL t7_run got done=%0b samples=%0d exp done=1 samples=8", got_done, nsamp);
        end
        sb.delete();
        @(negedge clk);
    endtask

    task automatic test_unsupported_and_start_ignored();
        exp_t e;
        bus.ic_type = 4'd9; bus.start = 1'b1; bus.ack = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        vectors++;
        if ({bus.unsupported, bus.busy} !== 2'b10 || bus.pin_oe !== 14'b0) begin
            miscompares++;
            $display("FAIL unsup_pulse got unsup=%b busy=%b oe=%b exp 1 0 0", bus.unsupported, bus.busy, bus.pin_oe);
        end
        @(negedge clk);
        vectors++;
        if ({bus.unsupported, bus.busy} !== 2'b00) begin
            miscompares++;
            $display("FAIL unsup_width got unsup=%b busy=%b exp 0 0", bus.unsupported, bus.busy);
        end
        bus.ic_type = 4'd0; bus.start = 1'b1;
        push_run(0);
        for (int c = 1; c <= 24; c++) begin
            @(negedge clk);
            bus.start = (c == 2 || c == 7 || c == 10);
            bus.ic_type = (c == 2) ? 4'd9 : (c >= 3 && c < 21) ? 4'd7 : 4'd0;
            vectors++;
            if (bus.unsupported !== 1'b0) begin
                miscompares++;
                $display("FAIL midrun_unsup c=%0d got 1 exp 0", c);
            end
            vectors++;
            if (bus.pin_oe !== ((c <= 20) ? exp_oe(0) : 14'b0) || bus.done !== (c == 21)) begin
                miscompares++;
                $display("FAIL midrun_run c=%0d got oe=%b done=%b exp oe=%b done=%b", c, bus.pin_oe, bus.done, (c <= 20) ? exp_oe(0) : 14'b0, (c == 21));
            end
            if (bus.sample_valid) begin
                if (sb.size() == 0) begin
                    vectors++; miscompares++;
                    $display("FAIL midrun_sb got empty exp entry");
                end else begin
                    e = sb.pop_front();
                    vectors++;
                    if (bus.vec_idx !== e.idx || bus.pin_out !== e.out) begin
                        miscompares++;
                        $display("FAIL midrun_vec got idx=%0d out=%b exp idx=%0d out=%b", bus.vec_idx, bus.pin_out, e.idx, e.out);
                    end
                end
            end
        end
        bus.start = 1'b0;
        sb.delete();
    endtask

    task automatic test_ack_hold_and_abort();
        exp_t e;
        logic [13:0] s_out, s_oe;
        logic [2:0] s_idx;
        int c = 0;
        bus.ic_type = 4'd0; bus.ack = 1'b0; bus.start = 1'b1;
        push_run(0);
        do begin
            @(negedge clk);
            bus.start = 1'b0;
            c++;
        end while (!bus.sample_valid && c < 20);
        vectors++;
        if (!bus.sample_valid || c != 5) begin
            miscompares++;
            $display("FAIL hold_first got valid=%b at c=%0d exp valid=1 at c=5", bus.sample_valid, c);
        end
        e = sb.pop_front();
        s_out = bus.pin_out; s_oe = bus.pin_oe; s_idx = bus.vec_idx;
        vectors++;
        if (s_idx !== e.idx || s_out !== e.out || s_oe !== exp_oe(0)) begin
            miscompares++;
            $display("FAIL hold_vec got idx=%0d out=%b oe=%b exp idx=%0d out=%b oe=%b", s_idx, s_out, s_oe, e.idx, e.out, exp_oe(0));
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            vectors++;
            if (!bus.sample_valid || bus.vec_idx !== s_idx || bus.pin_out !== s_out || bus.pin_oe !== s_oe) begin
                miscompares++;
                $display("FAIL hold_stable i=%0d got valid=%b idx=%0d out=%b exp valid=1 idx=%0d out=%b", i, bus.sample_valid, bus.vec_idx, bus.pin_out, s_idx, s_out);
            end
        end
        bus.abort = 1'b1; bus.ack = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0; bus.ack = 1'b0;
        vectors++;
        if ({bus.busy, bus.sample_valid, bus.done} !== 3'b000 || bus.pin_oe !== 14'b0) begin
            miscompares++;
            $display("FAIL abort_idle got busy=%b valid=%b done=%b oe=%b exp 0 0 0 0", bus.busy, bus.sample_valid, bus.done, bus.pin_oe);
        end
        @(negedge clk);
        vectors++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
            miscompares++;
            $display("FAIL abort_nodone got done=%b busy=%b exp 0 0", bus.done, bus.busy);
        end
        sb.delete();
    endtask

    task automatic test_reset_mid_drive();
        exp_t e;
        int nsamp = 0;
        bus.ic_type = 4'd0; bus.ack = 1'b1; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if (bus.pin_oe !== 14'b0 || bus.pin_out !== 14'b0 || bus.busy !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_async got oe=%b out=%b busy=%b exp 0 0 0", bus.pin_oe, bus.pin_out, bus.busy);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        bus.start = 1'b1;
        push_run(0);
        for (int c = 1; c <= 22; c++) begin
            @(negedge clk);
            bus.start = 1'b0;
            vectors++;
            if (bus.done !== (c == 21)) begin
                miscompares++;
                $display("FAIL rerun_done c=%0d got %b exp %b", c, bus.done, (c == 21));
            end
            if (bus.sample_valid) begin
                nsamp++;
                if (sb.size() == 0) begin
                    vectors++; miscompares++;
                    $display("FAIL rerun_sb got empty exp entry");
                end else begin
                    e = sb.pop_front();
                    vectors++;
                    if (bus.vec_idx !== e.idx || bus.pin_out !== e.out) begin
                        miscompares++;
                        $display("FAIL rerun_vec got idx=%0d out=%b exp idx=%0d out=%b", bus.vec_idx, bus.pin_out, e.idx, e.out);
                    end
                end
            end
        end
        vectors++;
        if (nsamp != 4) begin
            miscompares++;
            $display("FAIL rerun_count got %0d exp 4", nsamp);
        end
        sb.delete();
    endtask

    initial begin
        bus.start = 1'b0; bus.abort = 1'b0; bus.ack = 1'b0; bus.ic_type = 4'd0;
        test_reset();
        test_type0_ack_high();
        test_type5_type6();
        test_type7_random_ack();
        test_unsupported_and_start_ignored();
        test_ack_hold_and_abort();
        test_reset_mid_drive();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp completion");
        $fatal(1, "watchdog");
    end
endmodule
